reg_file_mp: RTL and testbench

- Parametrised successor to the CPU register file, adding configurable width/depth, N read ports, byte-enable writes, write-to-read bypass and a hardware clear engine.
- Sits in the decode stage of the MIPS datapath.
- After reset, and on request, the clear engine walks every entry to zero.
- The datapath stalls while `busy` is high.

---
 rtl/reg_file_mp.sv | 146 ++++++++++++++
 tb/tb_reg_file_mp.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/reg_file_mp.sv
// reg_file_mp: parameterised multi-port register file for the decode stage.
//   - One byte-masked write port, NUM_RD asynchronous read ports.
//   - Optional hardwired zero entry (ZERO_REG) and write-to-read bypass (BYPASS).
//   - A clear engine zeroes every entry after reset and on clear_req. While it
//     runs, busy is high, all reads return 0, and writes and clear_req are ignored.
// Ports:
//   clk, rst_n            clock, async active-low reset
//   write, WR, WD, byte_en write enable, address, data, per-byte mask
//   RR / RD               packed read addresses / read data, port p at slice p
//   clear_req             one-cycle clear request (honoured in IDLE only)
//   busy                  registered, high while clearing
// DATA_W must be a multiple of 8. NUM_RD must be in the range 1..4.

// Per-port read lane: selects the stored value, the bypassed write value or zero.
module reg_file_mp_rd_lane #(
  parameter int ADDR_W   = 5,
  parameter int DATA_W   = 32,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic              clearing,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_stored,
  input  logic              wr_fire,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_merged,
  output logic [DATA_W-1:0] rd_data
);
  logic is_zero, hit;

  assign is_zero = (ZERO_REG != 0) && (rd_addr == '0);
  assign hit     = (BYPASS != 0) && wr_fire && (rd_addr == wr_addr);

  // Zero beats bypass: the zero entry reads 0 even when it is the write target.
  always_comb begin
    rd_data = rd_stored;
    if (clearing || is_zero) rd_data = '0;
    else if (hit)            rd_data = wr_merged;
  end
endmodule

module reg_file_mp #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     write,
  input  logic [ADDR_W-1:0]        WR,
  input  logic [DATA_W-1:0]        WD,
  input  logic [DATA_W/8-1:0]      byte_en,
  input  logic [NUM_RD*ADDR_W-1:0] RR,
  output logic [NUM_RD*DATA_W-1:0] RD,
  input  logic                     clear_req,
  output logic                     busy
);
  localparam int DEPTH = 1 << ADDR_W;
  localparam int NB    = DATA_W / 8;

  typedef enum logic {S_CLEAR, S_IDLE} state_t;

  typedef struct packed {
    logic              en;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_req_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] clr_idx, clr_idx_nxt;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] wr_cur, wr_merged;
  logic              clearing;
  wr_req_t           wr;

  assign clearing = (state == S_CLEAR);

  // Byte merge of the incoming write with the current entry contents; this is
  // both what gets stored and what a bypassed read sees.
  assign wr_cur = mem[WR];
  for (genvar b = 0; b < NB; b++) begin : g_merge
    assign wr_merged[8*b +: 8] = byte_en[b] ? WD[8*b +: 8] : wr_cur[8*b +: 8];
  end

  // clear_req wins over a same-cycle write; writes to the zero entry never land.
  assign wr.en   = !clearing && write && !clear_req &&
                   !((ZERO_REG != 0) && (WR == '0));
  assign wr.addr = WR;
  assign wr.data = wr_merged;

  // Clear engine FSM
  always_comb begin
    state_nxt   = state;
    clr_idx_nxt = clr_idx;
    case (state)
      S_CLEAR: begin
        clr_idx_nxt = clr_idx + ADDR_W'(1);   // wraps to 0 after the last entry
        if (clr_idx == '1) state_nxt = S_IDLE;
      end
      S_IDLE: begin
        if (clear_req) begin
          state_nxt   = S_CLEAR;
          clr_idx_nxt = '0;
        end
      end
      default: begin
        state_nxt   = S_CLEAR;
        clr_idx_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_CLEAR;
      clr_idx <= '0;
      busy    <= 1'b1;
    end else begin
      state   <= state_nxt;
      clr_idx <= clr_idx_nxt;
      busy    <= (state_nxt == S_CLEAR);
    end
  end

  // Storage is not reset; the clear engine is what initialises it.
  always_ff @(posedge clk) begin
    if (clearing)   mem[clr_idx] <= '0;
    else if (wr.en) mem[wr.addr] <= wr.data;
  end

  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    reg_file_mp_rd_lane #(
      .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ZERO_REG(ZERO_REG), .BYPASS(BYPASS)
    ) u_lane (
      .clearing (clearing),
      .rd_addr  (RR[p*ADDR_W +: ADDR_W]),
      .rd_stored(mem[RR[p*ADDR_W +: ADDR_W]]),
      .wr_fire  (wr.en),
      .wr_addr  (wr.addr),
      .wr_merged(wr.data),
      .rd_data  (RD[p*DATA_W +: DATA_W])
    );
  end
endmodule

// File: tb/tb_reg_file_mp.sv
// Directed bench for reg_file_mp: a bypassing instance and a non-bypassing
// instance share all inputs so the pre-edge/forwarded read values can be compared.
module tb_reg_file_mp;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        write;
  logic [4:0]  WR;
  logic [31:0] WD;
  logic [3:0]  byte_en;
  logic [4:0]  rr0, rr1;
  logic        clear_req;
  logic [63:0] RD, RD_nb;
  logic        busy, busy_nb;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  reg_file_mp #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .ZERO_REG(1), .BYPASS(1)) dut (
    .clk(clk), .rst_n(rst_n), .write(write), .WR(WR), .WD(WD), .byte_en(byte_en),
    .RR({rr1, rr0}), .RD(RD), .clear_req(clear_req), .busy(busy)
  );

  reg_file_mp #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .ZERO_REG(1), .BYPASS(0)) dut_nb (
    .clk(clk), .rst_n(rst_n), .write(write), .WR(WR), .WD(WD), .byte_en(byte_en),
    .RR({rr1, rr0}), .RD(RD_nb), .clear_req(clear_req), .busy(busy_nb)
  );

  typedef struct {
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [3:0]  be;
    logic [4:0]  r0, r1;
    logic [31:0] e0, e1, e0_nb;
  } vec_t;

  vec_t vt[12];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Counts the DEPTH edges of a clear; busy must hold for 31 edges and drop on the 32nd.
  task automatic clear_walk(input string nm);
    for (int k = 1; k <= 32; k++) begin
      tick();
      chk({nm, "_busy"}, {31'd0, busy}, {31'd0, (k < 32)});
      if (k < 32) begin
        rr0 = 5'(k);
        rr1 = 5'(31 - k);
        #1;
        chk({nm, "_rd_during_clear"}, RD[31:0] | RD[63:32], 32'h0);
      end
    end
  endtask

  task automatic fill_hi();
    write = 1'b1; byte_en = 4'hF;
    for (int i = 20; i < 32; i++) begin
      WR = 5'(i); WD = 32'h0100_0000 + 32'(i);
      tick();
    end
    write = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    //          we    wa  wd             be    r0  r1  e0             e1             e0_nb
    vt[0]  = '{1'b1, 5, 32'hAABBCCDD, 4'hF, 5, 0, 32'hAABBCCDD, 32'h0,         32'h0};
    vt[1]  = '{1'b1, 5, 32'h11223344, 4'h5, 5, 5, 32'hAA22CC44, 32'hAA22CC44, 32'hAABBCCDD};
    vt[2]  = '{1'b0, 0, 32'h0,        4'h0, 5, 5, 32'hAA22CC44, 32'hAA22CC44, 32'hAA22CC44};
    vt[3]  = '{1'b1, 7, 32'h12345678, 4'hF, 7, 0, 32'h12345678, 32'h0,         32'h0};
    vt[4]  = '{1'b0, 0, 32'h0,        4'h0, 7, 5, 32'h12345678, 32'hAA22CC44, 32'h12345678};
    vt[5]  = '{1'b1, 0, 32'hFFFFFFFF, 4'hF, 0, 7, 32'h0,         32'h12345678, 32'h0};
    vt[6]  = '{1'b0, 0, 32'h0,        4'h0, 0, 0, 32'h0,         32'h0,         32'h0};
    vt[7]  = '{1'b1, 7, 32'hDEADBEEF, 4'h0, 7, 7, 32'h12345678, 32'h12345678, 32'h12345678};
    vt[8]  = '{1'b0, 0, 32'h0,        4'h0, 7, 6, 32'h12345678, 32'h0,         32'h12345678};
    vt[9]  = '{1'b1, 3, 32'hCAFEF00D, 4'hF, 3, 3, 32'hCAFEF00D, 32'hCAFEF00D, 32'h0};
    vt[10] = '{1'b1, 3, 32'h000000FF, 4'h8, 3, 5, 32'h00FEF00D, 32'hAA22CC44, 32'hCAFEF00D};
    vt[11] = '{1'b0, 0, 32'h0,        4'h0, 3, 7, 32'h00FEF00D, 32'h12345678, 32'h00FEF00D};

    rst_n = 1'b0; write = 1'b0; WR = '0; WD = '0; byte_en = '0;
    rr0 = 5'd4; rr1 = 5'd9; clear_req = 1'b0;

    // Reset and power-on clear
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", {31'd0, busy}, 32'd1);
    chk("reset_rd0", RD[31:0], 32'h0);
    rst_n = 1'b1;
    clear_walk("init");
    for (int i = 0; i < 32; i++) begin
      rr0 = 5'(i);
      #1;
      chk("init_entry_zero", RD[31:0], 32'h0);
    end

    // Directed vector table: inputs applied after an edge, outputs read mid-cycle
    for (int i = 0; i < 12; i++) begin
      tick();
      write = vt[i].we; WR = vt[i].wa; WD = vt[i].wd; byte_en = vt[i].be;
      rr0 = vt[i].r0; rr1 = vt[i].r1;
      @(negedge clk);
      chk($sformatf("vec%0d_rd0", i), RD[31:0], vt[i].e0);
      chk($sformatf("vec%0d_rd1", i), RD[63:32], vt[i].e1);
      chk($sformatf("vec%0d_nb_rd0", i), RD_nb[31:0], vt[i].e0_nb);
      chk($sformatf("vec%0d_busy", i), {31'd0, busy}, 32'd0);
    end
    tick();
    write = 1'b0;

    // Clear request colliding with a write to entry 3
    fill_hi();
    rr0 = 5'd25;
    #1;
    chk("fill_entry25", RD[31:0], 32'h01000019);
    clear_req = 1'b1; write = 1'b1; WR = 5'd3; WD = 32'h55555555; byte_en = 4'hF; rr0 = 5'd3;
    #1;
    chk("collide_busy_pre", {31'd0, busy}, 32'd0);
    chk("collide_no_bypass", RD[31:0], 32'h00FEF00D);
    tick();
    clear_req = 1'b0; WD = 32'hFFFFFFFF;
    chk("collide_busy_post", {31'd0, busy}, 32'd1);
    #1;
    chk("collide_rd_clear", RD[31:0], 32'h0);
    for (int k = 1; k <= 32; k++) begin
      tick();
      chk("reclear_busy", {31'd0, busy}, {31'd0, (k < 32)});
      clear_req = (k == 10);
    end
    clear_req = 1'b0; write = 1'b0;
    rr0 = 5'd3; rr1 = 5'd5;
    #1;
    chk("reclear_entry3", RD[31:0], 32'h0);
    chk("reclear_entry5", RD[63:32], 32'h0);
    rr0 = 5'd25;
    #1;
    chk("reclear_entry25", RD[31:0], 32'h0);

    // Reset asserted part-way through a clear (clr_idx = 17)
    fill_hi();
    rr0 = 5'd31;
    #1;
    chk("refill_entry31", RD[31:0], 32'h0100001F);
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    repeat (17) tick();
    rst_n = 1'b0;
    #1;
    chk("midclr_reset_busy", {31'd0, busy}, 32'd1);
    tick();
    tick();
    rst_n = 1'b1;
    clear_walk("midclr");
    for (int i = 20; i < 32; i++) begin
      rr0 = 5'(i);
      #1;
      chk($sformatf("midclr_entry%0d", i), RD[31:0], 32'h0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
